flex_event_detector: RTL

FLEX_EVENT_DETECTOR -- requirements
Module: flex_event_detector

---
 rtl/flex_event_detector_pkg.sv | 22 ++
 rtl/flex_event_detector_tick.sv | 22 ++
 rtl/flex_event_detector.sv | 118 +++++++++++
 3 files changed

// File: rtl/flex_event_detector_pkg.sv
// Shared definitions for the flex event detector: state encoding, widths, helpers.
package flex_event_detector_pkg;
  localparam int SAMPLE_W = 15;
  localparam int CNT_W    = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_LOW    = 2'd0;
  localparam state_t ST_ARM_HI = 2'd1;
  localparam state_t ST_HIGH   = 2'd2;
  localparam state_t ST_ARM_LO = 2'd3;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/flex_event_detector_tick.sv
// Evaluation strobe: one-clock tick every DECIM clocks, first one DECIM clocks after reset.
module flex_tick_gen #(
  parameter int DECIM = 64
) (
  input  logic clock_in,
  input  logic reset,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(DECIM - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clock_in) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/flex_event_detector.sv
// Hysteresis + dwell event detector on a decimated sample stream.
// Optional peak capture of each HIGH episode when FLEX_PEAK_TRACK_EN is defined.
module flex_event_detector
  import flex_event_detector_pkg::*;
#(
  parameter logic signed [14:0] THR_HI = 15'sd4000,
  parameter logic signed [14:0] THR_LO = 15'sd2000,
  parameter int DWELL = 8,
  parameter int DECIM = 64
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic signed [14:0]  signal_in,
  output logic                bent,
  output logic                rise_evt,
  output logic                fall_evt,
  output logic signed [14:0]  peak_out
);
  localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL);

  logic tick;
  flex_tick_gen #(.DECIM(DECIM)) u_tick (
    .clock_in (clock_in),
    .reset    (reset),
    .tick     (tick)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             bent_q, bent_d, rise_q, rise_d, fall_q, fall_d;
  logic             is_hi, is_lo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    is_hi   = (signal_in >= THR_HI);
    is_lo   = (signal_in <= THR_LO);
    cnt_inc = sat_inc(cnt_q);
    if (tick) begin
      case (state_q)
        ST_LOW: if (is_hi) begin
          if (DWELL == 1) begin state_d = ST_HIGH; rise_d = 1'b1; end
          else begin state_d = ST_ARM_HI; cnt_d = 8'd1; end
        end
        ST_ARM_HI: if (is_hi) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DWELL_C) begin state_d = ST_HIGH; cnt_d = '0; rise_d = 1'b1; end
        end else begin
          state_d = ST_LOW; cnt_d = '0;
        end
        ST_HIGH: if (is_lo) begin
          if (DWELL == 1) begin state_d = ST_LOW; fall_d = 1'b1; end
          else begin state_d = ST_ARM_LO; cnt_d = 8'd1; end
        end
        default: if (is_lo) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DWELL_C) begin state_d = ST_LOW; cnt_d = '0; fall_d = 1'b1; end
        end else begin
          state_d = ST_HIGH; cnt_d = '0;
        end
      endcase
    end
    // bent follows the committed level, so arming states keep the old one
    bent_d = (state_d == ST_HIGH) || (state_d == ST_ARM_LO);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      bent_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bent_q  <= bent_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bent     = bent_q;
  assign rise_evt = rise_q;
  assign fall_evt = fall_q;

`ifdef FLEX_PEAK_TRACK_EN
  sample_t run_pk_q, run_pk_d, pk_out_q, pk_out_d, pk_max;

  always_comb begin
    pk_max   = smax(run_pk_q, signal_in);
    run_pk_d = run_pk_q;
    pk_out_d = pk_out_q;
    if (tick) begin
      run_pk_d = (state_q == ST_LOW) ? signal_in : pk_max;
      // any landing in LOW (idle, aborted arm, completed fall) re-arms the tracker
      if (state_d == ST_LOW) run_pk_d = SAMPLE_MIN;
      if (fall_d)            pk_out_d = pk_max;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      run_pk_q <= SAMPLE_MIN;
      pk_out_q <= '0;
    end else begin
      run_pk_q <= run_pk_d;
      pk_out_q <= pk_out_d;
    end
  end

  assign peak_out = pk_out_q;
`else
  assign peak_out = '0;
`endif
endmodule
